// File: rtl/iiitb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iiitb_sync_fifo
// Description : Single-clock circular-buffer FIFO with registered full/empty.
// Revision    : 1.0 - initial release
// ============================================================================
module iiitb_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  write,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] iData,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0]   c_full_count = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_cnt_one    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   c_cnt_zero   = '0;
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one    = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_wr_en;
  logic                  w_rd_en;

  // Accepts are qualified by the registered flags, so a write while full or a
  // read while empty is dropped regardless of the other request.
  assign w_wr_en = write & ~full;
  assign w_rd_en = read  & ~empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= iData;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      oData    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_en) begin
        oData    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_nxt;
      full    <= (w_count_nxt == c_full_count);
      empty   <= (w_count_nxt == c_cnt_zero);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iiitb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiitb_sync_fifo
// Description : Scoreboard bench for iiitb_sync_fifo (fill, drain, stream,
//               wrap, mid-operation reset, random traffic).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iiitb_sync_fifo;

  localparam int c_dw    = 8;
  localparam int c_depth = 16;

  logic            CLK   = 1'b0;
  logic            RSTn  = 1'b1;
  logic            write = 1'b0;
  logic            read  = 1'b0;
  logic [c_dw-1:0] iData = '0;
  logic [c_dw-1:0] oData;
  logic            full;
  logic            empty;

  int n_cmp = 0;
  int n_err = 0;

  logic [c_dw-1:0] model_q [$];
  logic [c_dw-1:0] exp_q   [$];
  logic [c_dw-1:0] r_last_odata = '0;

  iiitb_sync_fifo #(
    .DATA_WIDTH(c_dw),
    .DEPTH     (c_depth),
    .ADDR_WIDTH(4)
  ) u_dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .write(write),
    .read (read),
    .iData(iData),
    .oData(oData),
    .full (full),
    .empty(empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle from the negedge; the model decides acceptance from its
  // own occupancy, and read results are queued for the post-edge compare.
  task automatic cycle(input logic wr, input logic rd, input logic [c_dw-1:0] d);
    logic w_ok;
    logic r_ok;
    logic [c_dw-1:0] exp;
    write = wr;
    read  = rd;
    iData = d;
    r_ok = rd && (model_q.size() > 0);
    w_ok = wr && (model_q.size() < c_depth);
    if (r_ok) exp_q.push_back(model_q.pop_front());
    if (w_ok) model_q.push_back(d);
    @(posedge CLK);
    #1;
    if (r_ok) begin
      exp = exp_q.pop_front();
      chk("odata", oData, exp);
      r_last_odata = exp;
    end else begin
      chk("odata_hold", oData, r_last_odata);
    end
    chk("full",  full,  (model_q.size() == c_depth));
    chk("empty", empty, (model_q.size() == 0));
    @(negedge CLK);
    write = 1'b0;
    read  = 1'b0;
  endtask

  initial begin
    // Reset state
    #1 RSTn = 1'b0;
    #2;
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_odata", oData, 0);
    #7 RSTn = 1'b1;
    @(negedge CLK);
    cycle(1'b0, 1'b0, 8'h00);
    chk("idle_empty", empty, 1);

    // Fill 1..16, then a 17th write is dropped
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    chk("fill_full", full, 1);
    cycle(1'b1, 1'b0, 8'd17);

    // Drain 16, then extra reads hold oData
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
    chk("drain_last", oData, 16);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b1, 1'b1, 8'h30);
    cycle(1'b0, 1'b1, 8'h00);

    // Streaming at occupancy 1
    for (int i = 0; i < 20; i++)
      cycle(model_q.size() < c_depth, model_q.size() > 0, 8'(8'h40 + i));
    chk("stream_occ", model_q.size(), 1);
    cycle(1'b0, 1'b1, 8'h00);

    // Pointer wrap: fill 16, read 8, write 17..24, read 16
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 8; i++)   cycle(1'b0, 1'b1, 8'h00);
    for (int i = 17; i <= 24; i++) cycle(1'b1, 1'b0, 8'(i));
    chk("wrap_full", full, 1);
    cycle(1'b1, 1'b1, 8'd99);
    cycle(1'b1, 1'b0, 8'd25);
    for (int i = 0; i < 16; i++)  cycle(1'b0, 1'b1, 8'h00);
    chk("wrap_last", oData, 25);

    // Mid-operation asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
    #2 RSTn = 1'b0;
    #1;
    chk("mrst_empty", empty, 1);
    chk("mrst_full",  full,  0);
    chk("mrst_odata", oData, 0);
    model_q.delete();
    exp_q.delete();
    r_last_odata = '0;
    #1 RSTn = 1'b1;
    @(negedge CLK);
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b1, 8'h00);
    chk("mrst_aa", oData, 8'hAA);

    // Random traffic
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    while (model_q.size() > 0) cycle(1'b0, 1'b1, 8'h00);
    chk("final_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
